lc3b_dm_cache: RTL and testbench

Parametrised direct-mapped, write-back, write-allocate cache between the LC-3b multicycle core's memory port and physical memory. It keeps the core-side handshake unchanged (read/write held until `mem_resp`). It converts misses into whole-line physical transfers. Line count and line size are set at elaboration, so the core can run against slow line-wide memory without changes.

---
 rtl/lc3b_dm_cache.sv | 172 +++++++++++++++++
 tb/tb_lc3b_dm_cache.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lc3b_dm_cache.sv
// Direct-mapped, write-back, write-allocate cache between the LC-3b core memory port and
// line-wide physical memory. Define LC3B_CACHE_STATS_EN to build the hit/miss counters.
module lc3b_dm_cache #(
    parameter int unsigned IDX_BITS = 3,
    parameter int unsigned OFF_BITS = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        mem_read,
    input  logic                        mem_write,
    input  logic [1:0]                  mem_byte_enable,
    input  logic [15:0]                 mem_address,
    input  logic [15:0]                 mem_wdata,
    output logic [15:0]                 mem_rdata,
    output logic                        mem_resp,
    output logic                        pmem_read,
    output logic                        pmem_write,
    output logic [15:0]                 pmem_address,
    output logic [(8 << OFF_BITS)-1:0]  pmem_wdata,
    input  logic [(8 << OFF_BITS)-1:0]  pmem_rdata,
    input  logic                        pmem_resp,
    output logic [15:0]                 hit_count,
    output logic [15:0]                 miss_count
);
    localparam int unsigned LINES  = 1 << IDX_BITS;
    localparam int unsigned LINE_W = 8 << OFF_BITS;
    localparam int unsigned TAG_W  = 16 - IDX_BITS - OFF_BITS;

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_CHECK     = 2'd1;
    localparam logic [1:0] S_WRITEBACK = 2'd2;
    localparam logic [1:0] S_FILL      = 2'd3;

    logic [1:0]        r_state;
    logic [LINES-1:0]  r_valid;
    logic [LINES-1:0]  r_dirty;
    logic [TAG_W-1:0]  r_tag  [LINES];
    logic [LINE_W-1:0] r_data [LINES];

    // Request is latched on leaving IDLE so no input reaches mem_resp combinationally.
    logic [15:1]       r_addr;
    logic [15:0]       r_wdata;
    logic [1:0]        r_be;
    logic              r_write;

    logic [TAG_W-1:0]    w_tag;
    logic [IDX_BITS-1:0] w_idx;
    logic [OFF_BITS-2:0] w_word;
    logic [LINE_W-1:0]   w_line;
    logic [LINE_W-1:0]   w_merged;
    logic                w_hit;
    logic                w_unused_addr0;

    assign w_unused_addr0 = mem_address[0];

    assign w_tag  = r_addr[15 -: TAG_W];
    assign w_idx  = r_addr[IDX_BITS+OFF_BITS-1:OFF_BITS];
    assign w_word = r_addr[OFF_BITS-1:1];
    assign w_line = r_data[w_idx];
    assign w_hit  = r_valid[w_idx] && (r_tag[w_idx] == w_tag);

    always_comb begin
        w_merged = w_line;
        if (r_be[0]) w_merged[{w_word, 4'b0000} +: 8] = r_wdata[7:0];
        if (r_be[1]) w_merged[{w_word, 4'b1000} +: 8] = r_wdata[15:8];
    end

    assign mem_resp   = (r_state == S_CHECK) && w_hit;
    assign mem_rdata  = mem_resp ? w_line[{w_word, 4'b0000} +: 16] : 16'h0000;
    assign pmem_write = (r_state == S_WRITEBACK);
    assign pmem_read  = (r_state == S_FILL);
    assign pmem_wdata = pmem_write ? w_line : '0;

    always_comb begin
        case (r_state)
            S_WRITEBACK: pmem_address = {r_tag[w_idx], w_idx, {OFF_BITS{1'b0}}};
            S_FILL:      pmem_address = {w_tag, w_idx, {OFF_BITS{1'b0}}};
            default:     pmem_address = 16'h0000;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_valid <= '0;
            r_dirty <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
            r_write <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (mem_read || mem_write) begin
                        r_state <= S_CHECK;
                        r_addr  <= mem_address[15:1];
                        r_wdata <= mem_wdata;
                        r_be    <= mem_byte_enable;
                        r_write <= mem_write;
                    end
                end
                S_CHECK: begin
                    if (w_hit) begin
                        r_state <= S_IDLE;
                        if (r_write && (r_be != 2'b00)) r_dirty[w_idx] <= 1'b1;
                    end else if (r_valid[w_idx] && r_dirty[w_idx]) begin
                        r_state <= S_WRITEBACK;
                    end else begin
                        r_state <= S_FILL;
                    end
                end
                S_WRITEBACK: begin
                    if (pmem_resp) r_state <= S_FILL;
                end
                S_FILL: begin
                    if (pmem_resp) begin
                        r_state        <= S_CHECK;
                        r_valid[w_idx] <= 1'b1;
                        r_dirty[w_idx] <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Tag and data arrays carry no reset; validity alone guards them.
    always_ff @(posedge clk) begin
        if ((r_state == S_CHECK) && w_hit && r_write) begin
            r_data[w_idx] <= w_merged;
        end else if ((r_state == S_FILL) && pmem_resp) begin
            r_data[w_idx] <= pmem_rdata;
            r_tag[w_idx]  <= w_tag;
        end
    end

`ifdef LC3B_CACHE_STATS_EN
    logic        r_from_idle;
    logic [15:0] r_hit_count;
    logic [15:0] r_miss_count;

    // Re-checks after a fill always hit and must not be counted as hits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_from_idle  <= 1'b0;
            r_hit_count  <= 16'h0000;
            r_miss_count <= 16'h0000;
        end else begin
            if (r_state == S_IDLE) begin
                r_from_idle <= 1'b1;
            end else if ((r_state == S_CHECK) && !w_hit) begin
                r_from_idle <= 1'b0;
            end
            if (r_state == S_CHECK) begin
                if (w_hit && r_from_idle && (r_hit_count != 16'hFFFF)) begin
                    r_hit_count <= r_hit_count + 16'h0001;
                end
                if (!w_hit && (r_miss_count != 16'hFFFF)) begin
                    r_miss_count <= r_miss_count + 16'h0001;
                end
            end
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
`else
    assign hit_count  = 16'h0000;
    assign miss_count = 16'h0000;
`endif

endmodule

// File: tb/tb_lc3b_dm_cache.sv
// Randomised self-checking bench for lc3b_dm_cache against an architectural memory model.
module tb_lc3b_dm_cache;
    localparam int LW = 128;

`ifdef LC3B_CACHE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          mem_read, mem_write;
    logic [1:0]    mem_byte_enable;
    logic [15:0]   mem_address, mem_wdata, mem_rdata;
    logic          mem_resp, pmem_read, pmem_write, pmem_resp;
    logic [15:0]   pmem_address, hit_count, miss_count;
    logic [LW-1:0] pmem_wdata, pmem_rdata;

    lc3b_dm_cache #(.IDX_BITS(3), .OFF_BITS(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_read(mem_read), .mem_write(mem_write), .mem_byte_enable(mem_byte_enable),
        .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_resp(mem_resp), .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_address(pmem_address), .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata),
        .pmem_resp(pmem_resp), .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    // Model: physical memory, what the core should observe, and per-line residency.
    logic [7:0] phys [65536];
    logic [7:0] arch [65536];
    bit   mv [8];
    bit   md [8];
    int   mt [8];
    int   mh, mm;

    int checks = 0, failures = 0, n_wb = 0;
    logic [15:0] last_rdata, last_fill_paddr, last_wb_paddr, last_wb_w2;

    task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [LW-1:0] line_of(input bit use_arch, input int base);
        logic [LW-1:0] l;
        for (int b = 0; b < 16; b++) l[b*8 +: 8] = use_arch ? arch[base+b] : phys[base+b];
        return l;
    endfunction

    task automatic chk_out(input string nm, input bit er, input bit epr, input bit epw,
                           input logic [15:0] ea, input logic [LW-1:0] ewd);
        if (pmem_write) n_wb++;
        chk({nm, ".mem_resp"}, mem_resp, er);
        chk({nm, ".pmem_read"}, pmem_read, epr);
        chk({nm, ".pmem_write"}, pmem_write, epw);
        chk({nm, ".pmem_address"}, pmem_address, ea);
        chk({nm, ".pmem_wdata"}, pmem_wdata, ewd);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            mv[i] = 1'b0;
            md[i] = 1'b0;
        end
        for (int i = 0; i < 65536; i++) arch[i] = phys[i];
        mh = 0;
        mm = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        mem_read = 1'b0;
        mem_write = 1'b0;
        pmem_resp = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Entered and left at a negedge with the DUT idle.
    task automatic run_req(input bit wr, input bit rd_too, input logic [15:0] a,
                           input logic [1:0] be, input logic [15:0] wd);
        int idx = (int'(a) >> 4) & 7;
        int tag = int'(a) >> 7;
        int base = int'(a) & 16'hFFF0;
        int wa = int'(a) & 16'hFFFE;
        bit hit = mv[idx] && (mt[idx] == tag);
        bit dty = !hit && mv[idx] && md[idx];
        int vbase = (mt[idx] << 7) | (idx << 4);
        int d;
        last_fill_paddr = 16'h0000;
        last_wb_paddr = 16'h0000;
        pmem_resp = 1'b0;
        mem_write = wr;
        mem_read = !wr || rd_too;
        mem_address = a;
        mem_byte_enable = be;
        mem_wdata = wd;
        @(negedge clk);
        if (!hit) begin
            chk_out("check_miss", 0, 0, 0, 16'h0000, '0);
            if (dty) begin
                d = $urandom_range(0, 3);
                for (int k = 0; k <= d; k++) begin
                    @(negedge clk);
                    if (k == 0) begin
                        last_wb_paddr = pmem_address;
                        last_wb_w2 = pmem_wdata[47:32];
                    end
                    chk_out("writeback", 0, 0, 1, 16'(vbase), line_of(1'b1, vbase));
                    pmem_rdata = {$urandom, $urandom, $urandom, $urandom};
                    pmem_resp = (k == d);
                end
                for (int b = 0; b < 16; b++) phys[vbase+b] = arch[vbase+b];
            end
            d = $urandom_range(0, 3);
            for (int k = 0; k <= d; k++) begin
                @(negedge clk);
                if (k == 0) last_fill_paddr = pmem_address;
                chk_out("fill", 0, 1, 0, 16'(base), '0);
                pmem_rdata = line_of(1'b0, base);
                pmem_resp = (k == d);
            end
            @(negedge clk);
            pmem_resp = 1'b0;
        end
        chk_out("respond", 1, 0, 0, 16'h0000, '0);
        if (wr) begin
            if (be[0]) arch[wa] = wd[7:0];
            if (be[1]) arch[wa+1] = wd[15:8];
        end else begin
            last_rdata = mem_rdata;
            chk("read_data", mem_rdata, {arch[wa+1], arch[wa]});
        end
        mem_read = 1'b0;
        mem_write = 1'b0;
        if (hit) mh = (mh < 65535) ? mh + 1 : mh;
        else mm = (mm < 65535) ? mm + 1 : mm;
        md[idx] = (hit && md[idx]) || (wr && (be != 2'b00));
        mv[idx] = 1'b1;
        mt[idx] = tag;
        @(negedge clk);
        chk_out("idle", 0, 0, 0, 16'h0000, '0);
        chk("hit_count", hit_count, STATS ? mh : 0);
        chk("miss_count", miss_count, STATS ? mm : 0);
    endtask

    initial begin
        int wb0;
        rst_n = 1'b0;
        mem_read = 1'b0;
        mem_write = 1'b0;
        mem_byte_enable = 2'b00;
        mem_address = 16'h0000;
        mem_wdata = 16'h0000;
        pmem_resp = 1'b0;
        pmem_rdata = '0;
        for (int i = 0; i < 65536; i++) phys[i] = 8'($urandom);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk_out("reset", 0, 0, 0, 16'h0000, '0);
        chk("reset.mem_rdata", mem_rdata, 16'h0000);
        chk("reset.hit_count", hit_count, 16'h0000);
        chk("reset.miss_count", miss_count, 16'h0000);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset while a fill is outstanding.
        mem_read = 1'b1;
        mem_address = 16'h4444;
        @(negedge clk);
        @(negedge clk);
        chk("rst_fill.pmem_read_before", pmem_read, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("rst_fill.pmem_read_after", pmem_read, 1'b0);
        chk("rst_fill.pmem_write_after", pmem_write, 1'b0);
        chk("rst_fill.mem_resp_after", mem_resp, 1'b0);
        mem_read = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_req(1'b0, 1'b0, 16'h4444, 2'b00, 16'h0000);
        chk("rst_fill.refill_addr", last_fill_paddr, 16'h4440);

        do_reset();
        phys[16'h1234] = 8'hEF;
        phys[16'h1235] = 8'hBE;
        arch[16'h1234] = 8'hEF;
        arch[16'h1235] = 8'hBE;
        run_req(1'b0, 1'b0, 16'h1234, 2'b00, 16'h0000);
        chk("cold.rdata", last_rdata, 16'hBEEF);
        chk("cold.fill_addr", last_fill_paddr, 16'h1230);
        chk("cold.miss_count", miss_count, STATS ? 16'd1 : 16'd0);
        run_req(1'b0, 1'b0, 16'h1234, 2'b00, 16'h0000);
        chk("warm.rdata", last_rdata, 16'hBEEF);
        chk("warm.no_fill", last_fill_paddr, 16'h0000);
        chk("warm.hit_count", hit_count, STATS ? 16'd1 : 16'd0);
        run_req(1'b1, 1'b0, 16'h1234, 2'b01, 16'h00AA);
        run_req(1'b0, 1'b0, 16'h1234, 2'b00, 16'h0000);
        chk("merge.rdata", last_rdata, 16'hBEAA);
        run_req(1'b0, 1'b0, 16'h1A34, 2'b00, 16'h0000);
        chk("evict.wb_addr", last_wb_paddr, 16'h1230);
        chk("evict.wb_word2", last_wb_w2, 16'hBEAA);
        chk("evict.fill_addr", last_fill_paddr, 16'h1A30);
        run_req(1'b0, 1'b0, 16'h2004, 2'b00, 16'h0000);
        run_req(1'b1, 1'b0, 16'h2004, 2'b00, 16'h5555);
        wb0 = n_wb;
        run_req(1'b0, 1'b0, 16'h2804, 2'b00, 16'h0000);
        chk("be0.no_writeback", n_wb - wb0, 0);
        chk("be0.fill_addr", last_fill_paddr, 16'h2800);

        for (int n = 0; n < 300; n++) begin
            int gap = $urandom_range(0, 2);
            logic [15:0] a;
            for (int g = 0; g < gap; g++) begin
                pmem_resp = 1'($urandom_range(0, 1));
                pmem_rdata = {$urandom, $urandom, $urandom, $urandom};
                @(negedge clk);
                chk_out("gap", 0, 0, 0, 16'h0000, '0);
            end
            a = 16'((($urandom_range(0, 3) + 32) << 7) | ($urandom_range(0, 7) << 4)
                    | $urandom_range(0, 15));
            run_req(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), a,
                    2'($urandom_range(0, 3)), 16'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
